// File: rtl/pnu_ce_reg_arbiter.sv
// pnu_ce_reg_arbiter
//   Round-robin write arbiter in front of one shared WIDTH-bit register
//   built from clock-enabled flops. Each grant lasts one cycle. The
//   winner's word is loaded only if it still requests in that cycle and
//   no clear is pending.
//
// Ports
//   clock  in   rising-edge clock
//   reset  in   asynchronous active-high reset
//   clr    in   synchronous clear of q / q_vld (owner and rr pointer kept)
//   req    in   [NREQ]        level requests, bit i = requester i
//   data   in   [NREQ*WIDTH]  requester i word at data[i*WIDTH +: WIDTH]
//   ack    out  [NREQ]        one-hot, high in the cycle a word is loaded
//   q      out  [WIDTH]       shared register
//   q_vld  out                q holds a loaded word since reset/clr
//   owner  out  [log2 NREQ]   requester of the last load
//   busy   out                high while in GRANT
module pnu_ce_reg_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clr,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   data,
  output logic [NREQ-1:0]         ack,
  output logic [WIDTH-1:0]        q,
  output logic                    q_vld,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy
);
  localparam int IW = $clog2(NREQ);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]      r_state;
  logic [IW-1:0]   r_gnt;
  logic [IW-1:0]   r_rr_ptr;
  logic [IW-1:0]   r_owner;
  logic [WIDTH-1:0] r_q;
  logic            r_vld;

  logic [IW-1:0]   w_win;
  logic [NREQ-1:0] w_ack;
  logic            w_ce;
  logic [WIDTH-1:0] w_data;

  // Winner = first set request above rr_ptr, wrapping. Walk the offsets
  // from farthest to nearest so the nearest hit is the last assignment.
  always_comb begin
    int idx;
    w_win = r_rr_ptr;
    for (int k = NREQ; k >= 1; k--) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) w_win = IW'(idx);
    end
  end

  // Ack is combinational so a withdrawn request or a clr in the grant
  // cycle kills the load on the same edge.
  always_comb begin
    w_ack = '0;
    if (r_state == ST_GRANT && req[r_gnt] && !clr) w_ack[r_gnt] = 1'b1;
  end

  assign w_ce = |w_ack;

  always_comb begin
    w_data = '0;
    for (int i = 0; i < NREQ; i++)
      if (r_gnt == IW'(i)) w_data = data[i*WIDTH +: WIDTH];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_gnt    <= '0;
      r_rr_ptr <= IW'(NREQ-1);
      r_owner  <= '0;
      r_q      <= '0;
      r_vld    <= 1'b0;
    end else begin
      if (clr) begin
        r_q   <= '0;
        r_vld <= 1'b0;
      end else if (w_ce) begin
        r_q      <= w_data;
        r_vld    <= 1'b1;
        r_owner  <= r_gnt;
        r_rr_ptr <= r_gnt;
      end
      case (r_state)
        ST_IDLE: begin
          if (!clr && |req) begin
            r_gnt   <= w_win;
            r_state <= ST_GRANT;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ack   = w_ack;
  assign q     = r_q;
  assign q_vld = r_vld;
  assign owner = r_owner;
  assign busy  = (r_state == ST_GRANT);

endmodule

// File: tb/tb_pnu_ce_reg_arbiter.sv
module tb_pnu_ce_reg_arbiter;
  logic        clock = 1'b0;
  logic        reset;
  logic        clr;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  ack;
  logic [7:0]  q;
  logic        q_vld;
  logic [1:0]  owner;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] dv [4];

  pnu_ce_reg_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clock(clock), .reset(reset), .clr(clr), .req(req), .data(data),
    .ack(ack), .q(q), .q_vld(q_vld), .owner(owner), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic set_data;
    data = {dv[3], dv[2], dv[1], dv[0]};
  endtask

  initial begin
    dv[0] = 8'h11; dv[1] = 8'h22; dv[2] = 8'h3C; dv[3] = 8'hFF;
    set_data();
    reset = 1'b1; clr = 1'b0; req = 4'b0000;
    tick(); tick();
    chk("rst_q", q, 0); chk("rst_vld", q_vld, 0); chk("rst_own", owner, 0);
    chk("rst_ack", ack, 0); chk("rst_busy", busy, 0);
    reset = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // All requesting from reset: rr starts at 3, so order 0,1,2,3,0
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_busy", busy, 1);
      chk("t3_ack", ack, 4'b0001 << (i % 4));
      tick();
      chk("t3_own", owner, i % 4);
      chk("t3_q", q, dv[i % 4]);
      chk("t3_gap_ack", ack, 0);
      chk("t3_gap_busy", busy, 0);
    end
    req = 4'b0000;
    tick();
    chk("t3_idle", busy, 0);

    // Single requester held: granted every other cycle
    req = 4'b0100;
    tick(); chk("t2_ack", ack, 4'b0100);
    tick(); chk("t2_q", q, 8'h3C); chk("t2_vld", q_vld, 1); chk("t2_own", owner, 2);
    chk("t2_ack0", ack, 0);
    tick(); chk("t2_ack_again", ack, 4'b0100);
    tick(); chk("t2_q2", q, 8'h3C);
    req = 4'b0000;
    tick();

    // Withdraw during grant: no load, rr stays at 2
    req = 4'b0010;
    tick(); chk("t4_ack", ack, 4'b0010);
    req = 4'b0000; #1;
    chk("t4_wd_ack", ack, 0); chk("t4_wd_busy", busy, 1);
    tick(); chk("t4_q", q, 8'h3C); chk("t4_own", owner, 2);
    // rr=2 picks 1 over 2 here; rr=1 would have picked 2
    req = 4'b0110;
    tick(); chk("t4_rr", ack, 4'b0010);
    tick(); chk("t4_q2", q, 8'h22); chk("t4_own2", owner, 1);
    req = 4'b0000;
    tick();

    // clr during grant of 3
    req = 4'b1000;
    tick(); chk("t5_ack", ack, 4'b1000);
    clr = 1'b1; #1;
    chk("t5_clr_ack", ack, 0);
    tick(); chk("t5_q", q, 0); chk("t5_vld", q_vld, 0); chk("t5_own", owner, 1);
    // clr in IDLE blocks arbitration
    req = 4'b0001;
    tick(); chk("t5_blk", busy, 0);
    clr = 1'b0;
    tick(); chk("t5_after", ack, 4'b0001);
    tick(); chk("t5_own0", owner, 0); chk("t5_vld1", q_vld, 1);
    req = 4'b0000;
    tick();

    // Wrap 3 -> 0
    req = 4'b1001;
    tick(); chk("t6_ack3", ack, 4'b1000);
    tick(); chk("t6_own3", owner, 3); chk("t6_q3", q, 8'hFF);
    tick(); chk("t6_ack0", ack, 4'b0001);
    tick(); chk("t6_own0", owner, 0); chk("t6_q0", q, 8'h11);
    req = 4'b0000;
    tick();

    // Reset mid-grant with q=A5
    dv[3] = 8'hA5; set_data();
    req = 4'b1000;
    tick(); tick(); chk("t1_pre", q, 8'hA5);
    tick(); chk("t1_grant", busy, 1);
    reset = 1'b1; #1;
    chk("t1_q", q, 0); chk("t1_vld", q_vld, 0); chk("t1_own", owner, 0);
    chk("t1_ack", ack, 0); chk("t1_busy", busy, 0);
    tick();
    req = 4'b0000;
    reset = 1'b0;
    tick(); chk("t1_idle", busy, 0); chk("t1_q2", q, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
